// File: rtl/pong_game_if.sv
// pong_game_if: beam position, buttons and pixel/score outputs between the timing generator and the pong engine.
interface pong_game_if;
  logic [9:0] counter_x;
  logic [8:0] counter_y;
  logic in_display_area;
  logic btn_left;
  logic btn_right;
  logic vga_r;
  logic vga_g;
  logic vga_b;
  logic [7:0] hit_count;
  logic [3:0] miss_count;
  modport master (
    output counter_x, counter_y, in_display_area, btn_left, btn_right,
    input vga_r, vga_g, vga_b, hit_count, miss_count
  );
  modport slave (
    input counter_x, counter_y, in_display_area, btn_left, btn_right,
    output vga_r, vga_g, vga_b, hit_count, miss_count
  );
endinterface

// File: rtl/pong_game.sv
// pong_game: single-player pong engine; updates ball and paddle once per frame and drives registered RGB.
module pong_game #(
  parameter logic [9:0] BALL_SIZE = 10'd8,
  parameter logic [9:0] BALL_SPEED = 10'd2,
  parameter logic [9:0] PADDLE_W = 10'd64,
  parameter logic [9:0] PADDLE_Y = 10'd464,
  parameter logic [9:0] PADDLE_STEP = 10'd4,
  parameter logic [7:0] SERVE_FRAMES = 8'd60
) (
  input logic clk,
  input logic rst,
  pong_game_if.slave bus
);
  typedef enum logic [2:0] {WAIT, PADDLE, COLLIDE, MOVE, SERVE} state_t;
  state_t state, state_nxt;
  logic [9:0] ball_x, paddle_x, by, bxe, bye, cx, cy;
  logic [8:0] ball_y;
  logic dir_x, dir_y;
  logic [7:0] serve_cnt, hit_cnt;
  logic [3:0] miss_cnt;
  logic [2:0] rgb, rgb_nxt;
  logic frame_tick, hit_l, hit_r, hit_t, hit_p, miss;
  logic do_paddle, do_collide, do_move;
  logic on_ball, on_paddle, on_border;
  assign frame_tick = bus.counter_x == 10'd0 && bus.counter_y == 9'd480;
  assign by = {1'b0, ball_y};
  assign bxe = ball_x + BALL_SIZE;
  assign bye = by + BALL_SIZE;
  // all collision terms look at pre-move state so they combine freely
  assign hit_l = !dir_x && ball_x <= 10'd8 + BALL_SPEED;
  assign hit_r = dir_x && bxe >= 10'd632 - BALL_SPEED;
  assign hit_t = !dir_y && by <= 10'd8 + BALL_SPEED;
  assign hit_p = dir_y && bye >= PADDLE_Y && bye <= PADDLE_Y + BALL_SPEED
                 && bxe > paddle_x && ball_x < paddle_x + PADDLE_W;
  assign miss = by >= 10'd480 - BALL_SIZE;
  always_ff @(posedge clk)
    state <= rst ? WAIT : state_nxt;
  always_comb
    state_nxt = state == WAIT ? (frame_tick ? PADDLE : WAIT)
              : state == PADDLE ? (serve_cnt != 8'd0 ? SERVE : COLLIDE)
              : state == COLLIDE ? (miss ? WAIT : MOVE)
              : WAIT;
  always_comb begin
    do_paddle = state == PADDLE;
    do_collide = state == COLLIDE;
    do_move = state == MOVE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      ball_x <= 10'd316;
      ball_y <= 9'd236;
      dir_x <= 1'b1;
      dir_y <= 1'b0;
      paddle_x <= 10'd288;
      serve_cnt <= SERVE_FRAMES;
      hit_cnt <= 8'd0;
      miss_cnt <= 4'd0;
    end else begin
      if (do_paddle) begin
        paddle_x <= bus.btn_left && !bus.btn_right
                      ? (paddle_x >= 10'd8 + PADDLE_STEP ? paddle_x - PADDLE_STEP : 10'd8)
                  : bus.btn_right && !bus.btn_left
                      ? (paddle_x + PADDLE_STEP <= 10'd632 - PADDLE_W ? paddle_x + PADDLE_STEP : 10'd632 - PADDLE_W)
                  : paddle_x;
        if (serve_cnt != 8'd0) serve_cnt <= serve_cnt - 8'd1;
      end
      if (do_collide) begin
        dir_x <= miss ? dir_x : hit_l | (dir_x & !hit_r);
        dir_y <= miss ? 1'b0 : hit_t | (dir_y & !hit_p);
        hit_cnt <= hit_cnt + {7'd0, hit_p};
        if (miss) begin
          miss_cnt <= miss_cnt + {3'd0, miss_cnt != 4'hf};
          ball_x <= 10'd316;
          ball_y <= 9'd236;
          serve_cnt <= SERVE_FRAMES;
        end
      end
      if (do_move) begin
        ball_x <= dir_x ? ball_x + BALL_SPEED : ball_x - BALL_SPEED;
        ball_y <= dir_y ? ball_y + BALL_SPEED[8:0] : ball_y - BALL_SPEED[8:0];
      end
    end
  assign cx = bus.counter_x;
  assign cy = {1'b0, bus.counter_y};
  assign on_ball = cx >= ball_x && cx < bxe && cy >= by && cy < bye;
  assign on_paddle = cx >= paddle_x && cx < paddle_x + PADDLE_W && cy >= PADDLE_Y && cy < PADDLE_Y + 10'd8;
  assign on_border = cx < 10'd8 || cx >= 10'd632 || cy < 10'd8;
  always_comb
    rgb_nxt = !bus.in_display_area ? 3'b000
            : on_ball ? 3'b111
            : on_paddle ? 3'b010
            : on_border ? 3'b001
            : 3'b000;
  always_ff @(posedge clk)
    rgb <= rst ? 3'b000 : rgb_nxt;
  assign bus.vga_r = rgb[2];
  assign bus.vga_g = rgb[1];
  assign bus.vga_b = rgb[0];
  assign bus.hit_count = hit_cnt;
  assign bus.miss_count = miss_cnt;
endmodule

// File: tb/tb_pong_game.sv
// tb_pong_game: directed frame-by-frame play-through of pong_game with hand-computed ball, paddle, score and pixel values.
module tb_pong_game;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  pong_game_if pif();
  pong_game dut (.clk(clk), .rst(rst), .bus(pif));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      pif.counter_x = 10'd0;
      pif.counter_y = 9'd480;
      @(negedge clk);
      pif.counter_y = 9'd481;
      repeat (3) @(negedge clk);
    end
  endtask
  task automatic pix(input string tag, input int x, input int y, input logic de, input logic [2:0] exp);
    @(negedge clk);
    pif.counter_x = 10'(x);
    pif.counter_y = 9'(y);
    pif.in_display_area = de;
    @(negedge clk);
    check(tag, 32'({pif.vga_r, pif.vga_g, pif.vga_b}), 32'(exp));
    pif.in_display_area = 1'b0;
    pif.counter_x = 10'd0;
    pif.counter_y = 9'd481;
  endtask
  task automatic ball(input string tag, input int x, input int y);
    check({tag, "_x"}, 32'(dut.ball_x), x);
    check({tag, "_y"}, 32'(dut.ball_y), y);
  endtask
  initial begin
    pif.counter_x = 10'd0;
    pif.counter_y = 9'd481;
    pif.in_display_area = 1'b0;
    pif.btn_left = 1'b0;
    pif.btn_right = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ball("rst_ball", 316, 236);
    check("rst_dir_x", 32'(dut.dir_x), 1);
    check("rst_dir_y", 32'(dut.dir_y), 0);
    check("rst_paddle", 32'(dut.paddle_x), 288);
    check("rst_hit", 32'(pif.hit_count), 0);
    check("rst_miss", 32'(pif.miss_count), 0);
    check("rst_rgb", 32'({pif.vga_r, pif.vga_g, pif.vga_b}), 0);
    pix("px_ball", 316, 236, 1'b1, 3'b111);
    pix("px_de_off", 316, 236, 1'b0, 3'b000);
    pix("px_border_l", 0, 100, 1'b1, 3'b001);
    pix("px_border_t", 320, 0, 1'b1, 3'b001);
    pix("px_border_r", 632, 100, 1'b1, 3'b001);
    pix("px_inner_r", 631, 100, 1'b1, 3'b000);
    pix("px_paddle", 300, 470, 1'b1, 3'b010);
    pix("px_paddle_end", 352, 470, 1'b1, 3'b000);
    tick(60);
    ball("serve60", 316, 236);
    pix("px_serve_ball", 316, 236, 1'b1, 3'b111);
    pix("px_ball_end", 324, 236, 1'b1, 3'b000);
    tick(1);
    ball("move1", 318, 234);
    tick(112);
    ball("pre_top", 542, 10);
    tick(1);
    ball("top", 544, 12);
    check("top_dir_y", 32'(dut.dir_y), 1);
    tick(39);
    ball("pre_right", 622, 90);
    tick(1);
    ball("right", 620, 92);
    check("right_dir_x", 32'(dut.dir_x), 0);
    tick(6);
    pif.btn_left = 1'b1;
    tick(10);
    check("paddle_l10", 32'(dut.paddle_x), 248);
    tick(90);
    check("paddle_l100", 32'(dut.paddle_x), 8);
    pif.btn_right = 1'b1;
    tick(10);
    check("paddle_both", 32'(dut.paddle_x), 8);
    pif.btn_left = 1'b0;
    tick(62);
    check("paddle_r62", 32'(dut.paddle_x), 256);
    pif.btn_right = 1'b0;
    tick(4);
    ball("pre_hit", 256, 456);
    check("pre_hit_cnt", 32'(pif.hit_count), 0);
    tick(1);
    ball("hit", 254, 454);
    check("hit_dir_y", 32'(dut.dir_y), 0);
    check("hit_cnt", 32'(pif.hit_count), 1);
    tick(122);
    ball("pre_left", 10, 210);
    tick(1);
    ball("left", 12, 208);
    check("left_dir_x", 32'(dut.dir_x), 1);
    tick(100);
    ball("top2", 212, 12);
    tick(158);
    pif.btn_right = 1'b1;
    tick(47);
    ball("pre_right2", 622, 422);
    tick(1);
    ball("right2", 620, 424);
    tick(19);
    check("paddle_r67", 32'(dut.paddle_x), 524);
    pif.btn_right = 1'b0;
    tick(1);
    ball("overlap", 580, 464);
    pix("px_overlap", 580, 464, 1'b1, 3'b111);
    pix("px_paddle_by_ball", 579, 464, 1'b1, 3'b010);
    pix("px_ball_corner", 587, 471, 1'b1, 3'b111);
    pix("px_past_both", 588, 466, 1'b1, 3'b000);
    tick(4);
    ball("pre_miss", 572, 472);
    tick(1);
    ball("miss", 316, 236);
    check("miss_cnt1", 32'(pif.miss_count), 1);
    check("miss_dir_x", 32'(dut.dir_x), 0);
    check("miss_dir_y", 32'(dut.dir_y), 0);
    tick(60);
    ball("miss_serve60", 316, 236);
    tick(1);
    ball("miss_move1", 314, 234);
    tick(5404);
    check("miss_cnt14", 32'(pif.miss_count), 14);
    tick(405);
    check("miss_cnt15", 32'(pif.miss_count), 15);
    tick(810);
    check("miss_sat", 32'(pif.miss_count), 15);
    check("hit_final", 32'(pif.hit_count), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
